prng_config_sequencer: RTL
==========================

PRNG_CONFIG_SEQUENCER -- requirements
Module: prng_config_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000: max cycles in RUN without a stream beat before abort.
REQ-002 ap_clk  in  1  single clock; all logic rising-edge.
REQ-003 ap_rst_n  in  1  asynchronous, active-low reset.
REQ-004 cfg_start  in  1  one-cycle request to configure and launch the generator; sampled only in IDLE.
REQ-005 cfg_seed  in  64  IEEE-754 double seed; captured on an accepted cfg_start.
REQ-006 cfg_n_bits  in  32  bits-per-sample value; captured with cfg_seed.
REQ-007 cfg_num_bits  in  32  total bits to generate; captured with cfg_seed.
REQ-008 m_axi_AWVALID  out  1;  m_axi_AWADDR  out  6;  m_axi_AWREADY  in  1  AXI-Lite master write-address channel.
REQ-009 m_axi_WVALID  out  1;  m_axi_WDATA  out  32;  m_axi_WREADY  in  1  write-data channel; WSTRB is not driven and is treated as all-ones.
REQ-010 m_axi_BVALID  in  1;  m_axi_BRESP  in  2;  m_axi_BREADY  out  1  write-response channel.
REQ-011 mon_TVALID, mon_TREADY, mon_TLAST  in  1 each  passive tap of the generator's 8-bit output stream.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse on normal completion.
REQ-014 error  out  1  sticky; cleared by the next accepted cfg_start.
REQ-015 beat_count  out  32  number of stream beats observed in the current or last run.

Function
REQ-016 States SHALL be IDLE, WR_SEED_LO, WR_SEED_HI, WR_NBITS, WR_NUMBITS, WR_START, RUN, FINISH.
REQ-017 IDLE -> WR_SEED_LO on cfg_start: capture the cfg_* inputs, clear beat_count and error.
REQ-018 Register writes, in this order: WR_SEED_LO 0x10 with cfg_seed[31:0]; WR_SEED_HI 0x14 with cfg_seed[63:32]; WR_NBITS 0x1C; WR_NUMBITS 0x24; WR_START 0x00 with data 0x00000001.
REQ-019 On entering a write state, AWVALID and WVALID SHALL both rise in the same cycle; AWADDR and WDATA stay stable while the matching VALID is high.
REQ-020 AWVALID drops the cycle after AWVALID&AWREADY; WVALID drops the cycle after WVALID&WREADY; the two channels complete independently, in either order or together.
REQ-021 BREADY is high in write states only after both AW and W have completed; B handshake = BVALID&BREADY.
REQ-022 On B handshake with BRESP==0: advance to the next state; WR_START advances to RUN.
REQ-023 On B handshake with BRESP!=0: set error, go to IDLE, no done pulse.
REQ-024 RUN: each cycle with mon_TVALID&mon_TREADY increments beat_count (wraps modulo 2^32).
REQ-025 A beat with mon_TLAST high is counted, then RUN -> FINISH.
REQ-026 FINISH: assert done for one cycle, then go to IDLE.
REQ-027 Idle counter in RUN clears on every beat; at TIMEOUT_CYCLES consecutive beatless cycles, set error and go to IDLE, no done.
REQ-028 cfg_start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-029 Write-channel latency: at least 1 cycle VALID-to-handshake; no combinational path from AWREADY, WREADY or BVALID to any output.

Reset
REQ-030 Reset value for every state register and output: AWVALID, WVALID, BREADY, busy, done, error = 0; AWADDR, WDATA, beat_count = 0; state = IDLE.
REQ-031 Reset asserted mid-transaction SHALL drop all VALID/READY outputs immediately (asynchronously) with no completion of the pending write.

Verification
REQ-032 Seed 0x3FE8000000000000, n_bits 5, num_bits 100, slave always ready, BRESP 0 -> five writes in order (0x10=0x00000000, 0x14=0x3FE80000, 0x1C=5, 0x24=100, 0x00=1), then RUN.
REQ-033 In RUN, 13 beats with TLAST on the 13th -> beat_count=13, single-cycle done pulse, busy low next cycle.
REQ-034 AWREADY 3 cycles before WREADY, and the reverse, on each write -> each VALID drops independently; BREADY only after both; same write sequence.
REQ-035 BRESP=2'b10 on the 0x1C write -> error=1, IDLE, no 0x24 or 0x00 write issued; next cfg_start clears error.
REQ-036 TIMEOUT_CYCLES=50, no beats after start -> error asserts exactly 50 cycles into RUN, no done.
REQ-037 cfg_start pulsed during RUN, and ap_rst_n pulled low during WR_NBITS -> pulse ignored; on reset all outputs = 0 and state = IDLE.

Source files
------------

// File: rtl/prng_config_sequencer.sv
// Programs the PRNG core's seed and lengths over AXI-Lite and starts it.
// It then counts output-stream beats until TLAST arrives or the stream goes idle for too long.
module prng_config_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        cfg_start,
  input  logic [63:0] cfg_seed,
  input  logic [31:0] cfg_n_bits,
  input  logic [31:0] cfg_num_bits,
  output logic        m_axi_AWVALID,
  output logic [5:0]  m_axi_AWADDR,
  input  logic        m_axi_AWREADY,
  output logic        m_axi_WVALID,
  output logic [31:0] m_axi_WDATA,
  input  logic        m_axi_WREADY,
  input  logic        m_axi_BVALID,
  input  logic [1:0]  m_axi_BRESP,
  output logic        m_axi_BREADY,
  input  logic        mon_TVALID,
  input  logic        mon_TREADY,
  input  logic        mon_TLAST,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] beat_count
);

  // state      | meaning
  // IDLE       | waiting for cfg_start
  // WR_SEED_LO | writing seed[31:0] to 0x10
  // WR_SEED_HI | writing seed[63:32] to 0x14
  // WR_NBITS   | writing n_bits to 0x1C
  // WR_NUMBITS | writing num_bits to 0x24
  // WR_START   | writing 1 to control register 0x00
  // RUN        | counting stream beats, watching for idle timeout
  // FINISH     | one-cycle done pulse
  typedef enum logic [2:0] {
    IDLE, WR_SEED_LO, WR_SEED_HI, WR_NBITS, WR_NUMBITS, WR_START, RUN, FINISH
  } state_t;

  localparam logic [31:0] TIMER_LOAD = 32'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  logic [31:0] seed_hi_q, n_bits_q, num_bits_q;
  logic [31:0] idle_timer;
  logic        aw_done, w_done;

  logic        in_write, b_hs, b_ok, beat, timeout, wr_load;
  logic        aw_done_n, w_done_n;
  logic [5:0]  wr_addr_next;
  logic [31:0] wr_data_next;

  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    in_write   = state inside {WR_SEED_LO, WR_SEED_HI, WR_NBITS, WR_NUMBITS, WR_START};
    b_hs       = in_write && m_axi_BVALID && m_axi_BREADY;
    b_ok       = (m_axi_BRESP == 2'b00);
    beat       = mon_TVALID && mon_TREADY;
    aw_done_n  = aw_done || (m_axi_AWVALID && m_axi_AWREADY);
    w_done_n   = w_done || (m_axi_WVALID && m_axi_WREADY);
    case (state)
      IDLE:       if (cfg_start) state_next = WR_SEED_LO;
      WR_SEED_LO: if (b_hs) state_next = b_ok ? WR_SEED_HI : IDLE;
      WR_SEED_HI: if (b_hs) state_next = b_ok ? WR_NBITS : IDLE;
      WR_NBITS:   if (b_hs) state_next = b_ok ? WR_NUMBITS : IDLE;
      WR_NUMBITS: if (b_hs) state_next = b_ok ? WR_START : IDLE;
      WR_START:   if (b_hs) state_next = b_ok ? RUN : IDLE;
      RUN: begin
        if (beat && mon_TLAST) begin
          state_next = FINISH;
        end else if (!beat && idle_timer <= 32'd1) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      FINISH:     state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // The low seed word is taken straight from the input because it is launched in the capture cycle.
  always_comb begin
    wr_addr_next = 6'h00;
    wr_data_next = 32'h0;
    case (state_next)
      WR_SEED_LO: begin wr_addr_next = 6'h10; wr_data_next = cfg_seed[31:0]; end
      WR_SEED_HI: begin wr_addr_next = 6'h14; wr_data_next = seed_hi_q;      end
      WR_NBITS:   begin wr_addr_next = 6'h1C; wr_data_next = n_bits_q;       end
      WR_NUMBITS: begin wr_addr_next = 6'h24; wr_data_next = num_bits_q;     end
      WR_START:   begin wr_addr_next = 6'h00; wr_data_next = 32'h1;          end
      default: ;
    endcase
    wr_load = (state_next != state) &&
              (state_next inside {WR_SEED_LO, WR_SEED_HI, WR_NBITS, WR_NUMBITS, WR_START});
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      seed_hi_q     <= '0;
      n_bits_q      <= '0;
      num_bits_q    <= '0;
      beat_count    <= '0;
      error         <= 1'b0;
      idle_timer    <= '0;
      m_axi_AWVALID <= 1'b0;
      m_axi_WVALID  <= 1'b0;
      m_axi_BREADY  <= 1'b0;
      m_axi_AWADDR  <= '0;
      m_axi_WDATA   <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
    end else begin
      if (state == IDLE && cfg_start) begin
        seed_hi_q  <= cfg_seed[63:32];
        n_bits_q   <= cfg_n_bits;
        num_bits_q <= cfg_num_bits;
        beat_count <= '0;
        error      <= 1'b0;
      end
      if ((b_hs && !b_ok) || timeout) error <= 1'b1;
      if (state == RUN && beat) beat_count <= beat_count + 32'd1;

      // Down-counter reloads outside RUN and on every beat.
      if (state != RUN || beat) idle_timer <= TIMER_LOAD;
      else                      idle_timer <= idle_timer - 32'd1;

      if (wr_load) begin
        m_axi_AWVALID <= 1'b1;
        m_axi_WVALID  <= 1'b1;
        m_axi_BREADY  <= 1'b0;
        m_axi_AWADDR  <= wr_addr_next;
        m_axi_WDATA   <= wr_data_next;
        aw_done       <= 1'b0;
        w_done        <= 1'b0;
      end else if (in_write) begin
        if (m_axi_AWVALID && m_axi_AWREADY) m_axi_AWVALID <= 1'b0;
        if (m_axi_WVALID && m_axi_WREADY)   m_axi_WVALID  <= 1'b0;
        aw_done      <= aw_done_n;
        w_done       <= w_done_n;
        m_axi_BREADY <= aw_done_n && w_done_n && !b_hs;
      end else begin
        m_axi_AWVALID <= 1'b0;
        m_axi_WVALID  <= 1'b0;
        m_axi_BREADY  <= 1'b0;
        aw_done       <= 1'b0;
        w_done        <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

endmodule
